// File: rtl/mem_responder.sv
// Byte-addressed big-endian memory behind an MFA/MOC request handshake with a
// fixed access latency and a side-band byte preload port.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Clear,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        Type,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [7:0]        LdData,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Busy,
  output logic [1:0]        o_dbg_state
);

  // Handshake: the initiator raises MFA with RW/Type/Address/DataIn and holds
  // MFA until it sees MOC=1; it then drops MFA, and MOC falls on the edge that
  // samples MFA=0. Request fields are captured once, on the accepting edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic [1:0]        r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data_out;
  logic              r_moc;
  logic [7:0]        r_mem [2**ADDR_W];

  logic [ADDR_W-1:0] w_align_addr;
  logic [ADDR_W-1:0] w_lane_addr [4];
  logic [7:0]        w_rd_byte [4];
  logic [7:0]        w_wr_byte [4];
  logic [3:0]        w_wr_en;
  logic [31:0]       w_rd_data;
  logic              w_access;
  logic              w_load;

  // Halfwords drop address bit 0, words (and the 11 encoding) drop bits 1:0.
  always_comb begin
    w_align_addr = Address;
    if (Type == 2'b01) begin
      w_align_addr = Address & ~ADDR_W'(1);
    end else if (Type[1]) begin
      w_align_addr = Address & ~ADDR_W'(3);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_lane_addr[i] = r_addr + ADDR_W'(i);
      w_rd_byte[i]   = r_mem[w_lane_addr[i]];
    end
  end

  // Lane 0 is the lowest address and therefore the most significant byte.
  always_comb begin
    w_wr_en   = 4'b0000;
    w_rd_data = 32'd0;
    for (int i = 0; i < 4; i++) begin
      w_wr_byte[i] = 8'd0;
    end
    case (r_type)
      2'b00: begin
        w_wr_en      = 4'b0001;
        w_wr_byte[0] = r_wdata[7:0];
        w_rd_data    = {24'd0, w_rd_byte[0]};
      end
      2'b01: begin
        w_wr_en      = 4'b0011;
        w_wr_byte[0] = r_wdata[15:8];
        w_wr_byte[1] = r_wdata[7:0];
        w_rd_data    = {16'd0, w_rd_byte[0], w_rd_byte[1]};
      end
      default: begin
        w_wr_en      = 4'b1111;
        w_wr_byte[0] = r_wdata[31:24];
        w_wr_byte[1] = r_wdata[23:16];
        w_wr_byte[2] = r_wdata[15:8];
        w_wr_byte[3] = r_wdata[7:0];
        w_rd_data    = {w_rd_byte[0], w_rd_byte[1], w_rd_byte[2], w_rd_byte[3]};
      end
    endcase
  end

  assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_load   = (r_state == IDLE) && !MFA && LdEn;

  // Storage is never reset; Clear only blocks writes landing on its edge.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      if (w_access && !r_rw) begin
        for (int i = 0; i < 4; i++) begin
          if (w_wr_en[i]) begin
            r_mem[w_lane_addr[i]] <= w_wr_byte[i];
          end
        end
      end else if (w_load) begin
        r_mem[LdAddr] <= LdData;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clear) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_moc      <= 1'b0;
      r_data_out <= 32'd0;
      r_rw       <= 1'b0;
      r_type     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MFA) begin
            r_rw    <= RW;
            r_type  <= Type;
            r_addr  <= w_align_addr;
            r_wdata <= DataIn;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (r_rw) begin
              r_data_out <= w_rd_data;
            end
            r_moc   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!MFA) begin
            r_moc   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign DataOut     = r_data_out;
  assign MOC         = r_moc;
  assign Busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning byte-address width (2**ADDR_W bytes stored).
REQ-002 SHALL have parameter LATENCY, default 2, range 1..15, meaning wait cycles between request acceptance and MOC.
REQ-003 SHALL have port Clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Clear, input, 1, meaning reset: synchronous and active-low.
REQ-005 SHALL have port MFA, input, 1, meaning memory function activate (request valid, held by initiator until MOC seen).
REQ-006 SHALL have port RW, input, 1, meaning 1 = read, 0 = write.
REQ-007 SHALL have port Type, input, 2, meaning 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 SHALL have port Address, input, ADDR_W, meaning byte address of the access.
REQ-009 SHALL have port DataIn, input, 32, meaning write data, right-justified.
REQ-010 SHALL have port LdEn, input, 1, meaning bench/boot preload strobe, one byte per cycle.
REQ-011 SHALL have port LdAddr, input, ADDR_W, meaning preload byte address.
REQ-012 SHALL have port LdData, input, 8, meaning preload byte.
REQ-013 SHALL have port DataOut, output, 32, meaning read data, right-justified, zero-extended.
REQ-014 SHALL have port MOC, output, 1, meaning memory operation complete.
REQ-015 SHALL have port Busy, output, 1, meaning 1 whenever state is not IDLE.

Function
REQ-016 SHALL store bytes in array Mem[0 .. 2**ADDR_W-1]; multi-byte data big-endian (lowest address = most significant byte).
REQ-017 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-018 IDLE: MFA=1 sampled -> latch RW, Type, Address, DataIn; load counter with LATENCY-1; go to WAIT.
REQ-019 WAIT: counter nonzero -> decrement; counter zero -> perform access, set MOC=1, go to DONE.
REQ-020 Result: MOC high at the edge LATENCY cycles after the accepting edge; for LATENCY=2, accept at edge k, MOC=1 after edge k+2.
REQ-021 DONE: MOC stays 1 and DataOut stays stable while MFA=1; MFA=0 sampled -> MOC=0 and IDLE at that edge.
REQ-022 MFA SHALL be ignored in WAIT; changes to RW, Type, Address and DataIn after acceptance SHALL have no effect.
REQ-023 Address alignment: halfword forces Address[0]=0; word forces Address[1:0]=0 (silent align-down, no error).
REQ-024 Multi-byte addresses SHALL wrap modulo 2**ADDR_W.
REQ-025 Read: DataOut = {24'b0,byte}, {16'b0,half} or full word; DataOut updates only on the access edge.
REQ-026 Write: only the 1, 2 or 4 addressed bytes change; DataOut unchanged.
REQ-027 Preload: LdEn=1 in IDLE with MFA=0 -> Mem[LdAddr]=LdData at that edge.
REQ-028 LdEn SHALL be ignored when MFA=1 in IDLE (request wins) and in WAIT or DONE.
REQ-029 Busy SHALL be combinational from state.

Reset
REQ-030 Clear=0 at an edge SHALL force IDLE, MOC=0, DataOut=0, counter=0, from any state, including mid-WAIT.
REQ-031 A reset-aborted write SHALL leave Mem unchanged.
REQ-032 Reset SHALL NOT clear Mem contents.
REQ-033 Reset dominates MFA and LdEn in the same cycle.

Verification
REQ-034 Preload bytes 8'h12, 34, 56, 78 at addresses 0..3; word read at 0 -> DataOut=32'h12345678, MOC high exactly 2 edges after acceptance.
REQ-035 With that preload, halfword read at address 3 -> aligned to 2, DataOut=32'h00005678; byte read at 1 -> 32'h00000034.
REQ-036 Byte write 8'hAB at address 2, then word read at 0 -> 32'h1234AB78; hold MFA 5 cycles in DONE -> MOC and DataOut stable throughout.
REQ-037 Word write 32'hDEADBEEF at address 255 (ADDR_W=8) -> aligned to 252, bytes 252..255 = DE, AD, BE, EF; bytes 0..3 untouched.
REQ-038 Word write accepted, Clear=0 during WAIT -> MOC=0, IDLE next edge; following word read at target returns the old contents.
REQ-039 LdEn pulsed in WAIT and in DONE with LdData=8'hFF -> memory unchanged; same pulse in IDLE with MFA=0 -> byte written.
